// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Define BTB_STATS_EN to add lookup/update/mispredict statistics ports.
module btb_predictor #(
  parameter int PC_W     = 16,
  parameter int IDX_W    = 4,
  parameter int TAG_W    = 12,
  parameter int CTR_INIT = 1
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_mispredict,
  input  logic            flush_all
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [1:0] CTR_RST = 2'(CTR_INIT);

  logic              v_q   [ENTRIES];
  logic [TAG_W-1:0]  tag_q [ENTRIES];
  logic [PC_W-1:0]   tgt_q [ENTRIES];
  logic [1:0]        ctr_q [ENTRIES];

  logic [IDX_W-1:0]  l_idx;
  logic [TAG_W-1:0]  l_tag;
  logic [IDX_W-1:0]  u_idx;
  logic [TAG_W-1:0]  u_tag;
  logic              u_hit;
  logic [1:0]        u_ctr;

  assign l_idx = lookup_pc[IDX_W-1:0];
  assign l_tag = lookup_pc[IDX_W+TAG_W-1:IDX_W];
  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[IDX_W+TAG_W-1:IDX_W];

  // Lookup sees only pre-edge contents; no bypass from a same-cycle update.
  always_comb begin
    pred_hit    = v_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = pred_hit && ctr_q[l_idx][1];
    pred_target = pred_taken ? tgt_q[l_idx]
                             : lookup_pc + PC_W'(1);
  end

  always_comb begin
    u_hit = v_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr = ctr_q[u_idx];
    if (upd_taken) begin
      if (u_ctr != 2'd3) u_ctr = u_ctr + 2'd1;
    end else begin
      if (u_ctr != 2'd0) u_ctr = u_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        v_q[i]   <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_RST;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) v_q[i] <= 1'b0;
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr;
        if (upd_taken) tgt_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        // Allocation evicts any occupant and starts weakly taken.
        v_q[u_idx]   <= 1'b1;
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= upd_target;
        ctr_q[u_idx] <= 2'd2;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (!Rst) begin
      stat_lookups     <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_lookups <= stat_lookups + 32'd1;
      if (upd_valid && !flush_all) begin
        stat_updates <= stat_updates + 32'd1;
        if (upd_mispredict)
          stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{upd_pc, upd_mispredict};

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: reference table model,
// expected lookups queued at drive time and compared at negedge.
module tb_btb_predictor;

  logic        clk;
  logic        Rst;
  logic [15:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_mispredict;
  logic        flush_all;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  btb_predictor dut (
    .clk            (clk),
    .Rst            (Rst),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .flush_all      (flush_all)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [15:0] tgt;
  } exp_t;

  exp_t exp_q[$];

  logic        m_v   [16];
  logic [11:0] m_tag [16];
  logic [15:0] m_tgt [16];
  logic [1:0]  m_ctr [16];
  logic [31:0] m_lk, m_up, m_mp;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_lookup(input logic [15:0] pc);
    exp_t e;
    int i;
    i = int'(pc[3:0]);
    e.hit   = m_v[i] && (m_tag[i] == pc[15:4]);
    e.taken = e.hit && (m_ctr[i] >= 2'd2);
    e.tgt   = e.taken ? m_tgt[i] : 16'(pc + 16'd1);
    return e;
  endfunction

  task automatic model_edge(input logic rst_n, input logic fl,
                            input logic uv, input logic [15:0] upc,
                            input logic ut, input logic [15:0] utg,
                            input logic um);
    int i;
    i = int'(upc[3:0]);
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        m_v[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 2'd1;
      end
      m_lk = 0; m_up = 0; m_mp = 0;
    end else begin
      m_lk = m_lk + 1;
      if (fl) begin
        for (int k = 0; k < 16; k++) m_v[k] = 1'b0;
      end else if (uv) begin
        m_up = m_up + 1;
        if (um) m_mp = m_mp + 1;
        if (m_v[i] && m_tag[i] == upc[15:4]) begin
          if (ut) begin
            if (m_ctr[i] < 2'd3) m_ctr[i] = m_ctr[i] + 2'd1;
            m_tgt[i] = utg;
          end else if (m_ctr[i] > 2'd0) begin
            m_ctr[i] = m_ctr[i] - 2'd1;
          end
        end else if (ut) begin
          m_v[i] = 1'b1; m_tag[i] = upc[15:4];
          m_tgt[i] = utg; m_ctr[i] = 2'd2;
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic [15:0] lpc,
                      input logic uv, input logic [15:0] upc,
                      input logic ut, input logic [15:0] utg,
                      input logic um, input logic fl,
                      input logic rst_n);
    exp_t e;
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg; upd_mispredict = um;
    flush_all = fl; Rst = rst_n;
    exp_q.push_back(model_lookup(lpc));
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".hit"}, 32'(pred_hit), 32'(e.hit));
    check({tag, ".taken"}, 32'(pred_taken), 32'(e.taken));
    check({tag, ".target"}, 32'(pred_target), 32'(e.tgt));
    @(posedge clk);
    model_edge(rst_n, fl, uv, upc, ut, utg, um);
    #1;
`ifdef BTB_STATS_EN
    check({tag, ".stat_lk"}, stat_lookups, m_lk);
    check({tag, ".stat_up"}, stat_updates, m_up);
    check({tag, ".stat_mp"}, stat_mispredicts, m_mp);
`endif
  endtask

  task automatic look(input string tag, input logic [15:0] lpc);
    step(tag, lpc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic upd(input string tag, input logic [15:0] lpc,
                     input logic [15:0] upc, input logic ut,
                     input logic [15:0] utg);
    step(tag, lpc, 1'b1, upc, ut, utg, 1'b0, 1'b0, 1'b1);
  endtask

  logic [15:0] pcs [6];

  initial begin
    Rst = 1'b0; lookup_pc = 16'h0010; upd_valid = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_mispredict = 1'b0; flush_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_edge(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

    step("rst_hold", 16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0040,
         1'b0, 1'b1, 1'b0);
    look("after_rst", 16'h0010);

    upd("alloc_same", 16'h0010, 16'h0010, 1'b1, 16'h0040);
    look("alloc_hit", 16'h0010);
    upd("nt1", 16'h0010, 16'h0010, 1'b0, 16'h0);
    upd("nt2", 16'h0010, 16'h0010, 1'b0, 16'h0);
    upd("nt_sat", 16'h0010, 16'h0010, 1'b0, 16'h0);
    look("ctr0", 16'h0010);
    for (int k = 0; k < 4; k++)
      upd("tk_up", 16'h0010, 16'h0010, 1'b1, 16'h0044);
    look("ctr3", 16'h0010);
    upd("sat_dn1", 16'h0010, 16'h0010, 1'b0, 16'h0);
    upd("sat_dn2", 16'h0010, 16'h0010, 1'b0, 16'h0);
    look("ctr1", 16'h0010);

    upd("alias", 16'h0020, 16'h0020, 1'b1, 16'h0080);
    look("evicted", 16'h0010);
    look("alias_hit", 16'h0020);
    upd("nt_miss", 16'h0011, 16'h0011, 1'b0, 16'h0099);
    look("nt_miss_chk", 16'h0011);

    upd("same_cyc", 16'h0030, 16'h0030, 1'b1, 16'h0050);
    look("next_cyc", 16'h0030);

    look("wrap", 16'hFFFF);
    upd("wrap_alloc", 16'hFFFF, 16'hFFFF, 1'b1, 16'h1234);
    look("wrap_hit", 16'hFFFF);

    step("flush_upd", 16'h0030, 1'b1, 16'h0007, 1'b1, 16'h0077,
         1'b1, 1'b1, 1'b1);
    look("flushed_a", 16'h0030);
    look("flushed_b", 16'h0007);
    look("flushed_c", 16'hFFFF);

    upd("refill", 16'h0005, 16'h0005, 1'b1, 16'h0505);
    step("rst_upd", 16'h0005, 1'b1, 16'h0006, 1'b1, 16'h0606,
         1'b0, 1'b0, 1'b0);
    look("post_rst_a", 16'h0005);
    look("post_rst_b", 16'h0006);

    pcs[0] = 16'h0010; pcs[1] = 16'h0020; pcs[2] = 16'h0030;
    pcs[3] = 16'h0011; pcs[4] = 16'h0005; pcs[5] = 16'hFFFF;
    for (int n = 0; n < 300; n++) begin
      step("rand", pcs[$urandom_range(0, 5)],
           1'($urandom_range(0, 3) != 0), pcs[$urandom_range(0, 5)],
           1'($urandom_range(0, 2) != 0), 16'($urandom()),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 60) != 0));
    end

    if (exp_q.size() != 0)
      check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined core.
- The fetch stage presents the current PC and receives a same-cycle prediction of the next PC, which replaces the stall-on-branch scheme.
- The execute stage writes each resolved branch back into the table.
- Direct-mapped, word-addressed; the fall-through PC is PC+1.

Parameters:
PC_W, 16, PC / target width in bits.
IDX_W, 4, index bits; table depth ENTRIES = 2**IDX_W.
TAG_W, 12, tag bits taken from pc[IDX_W+TAG_W-1:IDX_W]; IDX_W+TAG_W <= PC_W is required.
CTR_INIT, 1, counter value loaded into every entry at reset (0..3).

Ports:
clk  in  1  clock, rising edge.
Rst  in  1  reset, synchronous, active-low.
lookup_pc  in  PC_W  PC being fetched this cycle.
pred_hit  out  1  valid entry whose tag matches lookup_pc.
pred_taken  out  1  pred_hit AND counter[1].
pred_target  out  PC_W  stored target if pred_taken, else lookup_pc+1 (mod 2**PC_W).
upd_valid  in  1  resolved branch present this cycle.
upd_pc  in  PC_W  PC of the resolved branch.
upd_taken  in  1  actual branch outcome.
upd_target  in  PC_W  actual taken target.
upd_mispredict  in  1  the execute stage detected a wrong prediction for this branch (used by stats only).
flush_all  in  1  invalidate the entire table.

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (PC_W), ctr (2).
- index = pc[IDX_W-1:0]; tag = pc[IDX_W+TAG_W-1:IDX_W].
- Lookup is purely combinational from lookup_pc and the current table contents (zero latency).
- Lookup never sees an update from the same cycle; it returns the pre-edge contents, with no bypass.
- Updates are registered and take effect on the posedge where upd_valid=1; they are visible to lookup from the next cycle.
- Update hit (entry valid and tags match):
  - upd_taken=1: ctr = min(ctr+1, 3) and target = upd_target.
  - upd_taken=0: ctr = max(ctr-1, 0); target is unchanged.
  - valid stays 1.
- Update miss (invalid entry or tag mismatch):
  - upd_taken=1: allocate. valid=1, tag written, target=upd_target, ctr=2 (weakly taken). Any previous occupant is overwritten.
  - upd_taken=0: no change to the table.
- Counter saturation: 3 + taken stays 3; 0 + not-taken stays 0. The counter never wraps.
- flush_all=1: every valid bit clears on that edge. Any coincident update is discarded. Tags, targets and counters are retained but unreachable.
- Reset (Rst=0 at the edge):
  - All valid bits clear and all ctr = CTR_INIT; targets and tags are cleared to 0.
  - Reset takes priority over flush_all and upd_valid, including mid-stream.
- Output values during and after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+1.
- Priority order at an edge: Rst > flush_all > upd_valid.
- Wrap-around: lookup_pc = 2**PC_W-1 with no hit gives pred_target = 0.
- Aliasing: PCs with equal index and equal tag but differing upper bits beyond IDX_W+TAG_W share an entry. This is accepted behaviour.

Optional Feature:
- Macro: BTB_STATS_EN.
- When defined, three extra output ports exist:
  - stat_lookups [31:0]: increments every cycle Rst=1.
  - stat_updates [31:0]: increments on every accepted update (upd_valid=1, flush_all=0).
  - stat_mispredicts [31:0]: increments on every accepted update with upd_mispredict=1.
- The stats counters wrap at 2**32, clear on reset, and are not cleared by flush_all.
- When not defined, these ports and their logic are absent and upd_mispredict is ignored.

Test Plan:
- Reset then lookup_pc=16'h0010 -> pred_hit=0, pred_taken=0, pred_target=16'h0011.
- Update pc=16'h0010, taken=1, target=16'h0040; next cycle lookup 16'h0010 -> pred_hit=1, pred_taken=1, pred_target=16'h0040.
- Then two not-taken updates to 16'h0010 -> ctr goes 2→1→0; lookup gives pred_hit=1, pred_taken=0, pred_target=16'h0011. Three further taken updates -> ctr saturates at 3; a fourth taken update leaves ctr at 3.
- Alias eviction: allocate 16'h0010→16'h0040, then taken update pc=16'h0020 (same index 0, different tag) target 16'h0080 -> lookup 16'h0010 misses; lookup 16'h0020 hits with pred_target 16'h0080.
- Same-cycle lookup and update on 16'h0030 (taken, target 16'h0050) -> that cycle pred_hit=0; the following cycle pred_hit=1 with pred_target 16'h0050. flush_all coincident with a taken update -> table empty and update discarded. Rst=0 asserted with upd_valid=1 -> all lookups miss afterwards.
- With BTB_STATS_EN: 10 cycles out of reset, 3 accepted updates of which 1 is marked mispredict, then flush_all -> stat_lookups=10, stat_updates=3, stat_mispredicts=1, all unchanged by the flush.
